// File: rtl/pid_sched_pkg.sv
// Shared types for the PID gain scheduler: state encoding, gain bundle,
// and the saturating |error| helper.
package pid_sched_pkg;

  localparam int GAIN_W = 16;
  localparam int LVL_W  = 2;
  localparam logic [LVL_W-1:0] MAX_LEVEL = 2'd3;

  typedef enum logic [1:0] {
    ST_NOMINAL    = 2'd0,
    ST_DERATED    = 2'd1,
    ST_SETTLING   = 2'd2,
    ST_RECOVERING = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [GAIN_W-1:0] kp;
    logic [GAIN_W-1:0] ki;
    logic [GAIN_W-1:0] kd;
  } gains_t;

  // -2^31 has no positive twin, so it folds onto 2^31-1
  function automatic logic [31:0] abs_sat(input logic signed [31:0] v);
    if (v == 32'sh8000_0000) return 32'h7FFF_FFFF;
    else if (v < 0)          return 32'(-v);
    else                     return 32'(v);
  endfunction

endpackage

// File: rtl/pid_gain_scaler.sv
// Combinational gain derate: kp/ki halve per level, kd grows by a quarter
// of nominal per level and clips at full scale.
module pid_gain_scaler
  import pid_sched_pkg::*;
(
  input  gains_t             i_nom,
  input  logic [LVL_W-1:0]   i_level,
  output gains_t             o_gains
);

  logic [GAIN_W:0] w_kd_step;
  logic [GAIN_W:0] w_kd_sum;

  assign w_kd_step = (GAIN_W+1)'(i_nom.kd >> 2) * (GAIN_W+1)'(i_level);
  assign w_kd_sum  = (GAIN_W+1)'(i_nom.kd) + w_kd_step;

  assign o_gains.kp = i_nom.kp >> i_level;
  assign o_gains.ki = i_nom.ki >> i_level;
  assign o_gains.kd = w_kd_sum[GAIN_W] ? {GAIN_W{1'b1}} : w_kd_sum[GAIN_W-1:0];

endmodule

// File: rtl/pid_gain_scheduler.sv
// Overshoot-driven PID gain scheduler: derates in steps while overshoot
// persists, waits for the error to settle, then steps gains back up.
module pid_gain_scheduler
  import pid_sched_pkg::*;
#(
  parameter int unsigned        DWELL_TICKS   = 50,
  parameter int unsigned        SETTLE_TICKS  = 200,
  parameter int unsigned        RECOVER_TICKS = 100,
  parameter logic signed [31:0] SETTLE_BAND   = 32'sd100,
  parameter logic [15:0]        KP_DEFAULT    = 16'd1024,
  parameter logic [15:0]        KI_DEFAULT    = 16'd64,
  parameter logic [15:0]        KD_DEFAULT    = 16'd256
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_100k_enable,
  input  logic                overshoot_detected,
  input  logic signed [31:0]  error_pos,
  input  logic                cfg_load,
  input  logic [GAIN_W-1:0]   kp_cfg,
  input  logic [GAIN_W-1:0]   ki_cfg,
  input  logic [GAIN_W-1:0]   kd_cfg,
  output logic [GAIN_W-1:0]   kp_out,
  output logic [GAIN_W-1:0]   ki_out,
  output logic [GAIN_W-1:0]   kd_out,
  output logic                gain_update,
  output logic [1:0]          derate_level,
  output logic [1:0]          sched_state,
  output logic                saturated
);

  localparam logic [31:0] DWELL_LAST   = 32'(DWELL_TICKS - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_TICKS - 1);
  localparam logic [31:0] RECOVER_LAST = 32'(RECOVER_TICKS - 1);
  localparam gains_t      DEFAULTS     = '{kp: KP_DEFAULT, ki: KI_DEFAULT, kd: KD_DEFAULT};

  sched_state_e       r_state, w_state_nx;
  logic [LVL_W-1:0]   r_lvl, w_lvl_nx;
  logic [31:0]        r_cnt, w_cnt_nx;
  logic               r_sat, w_sat_nx;
  gains_t             r_nom, r_pend, r_out;
  logic               r_pend_vld;
  logic               r_upd;

  gains_t             w_cfg;
  gains_t             w_scaled;
  logic [31:0]        w_abs_err;
  logic               w_in_band;
  logic               w_enter_nom;

  assign w_cfg       = '{kp: kp_cfg, ki: ki_cfg, kd: kd_cfg};
  assign w_abs_err   = abs_sat(error_pos);
  assign w_in_band   = $signed({1'b0, w_abs_err}) <= 33'(SETTLE_BAND);
  assign w_enter_nom = (r_state != ST_NOMINAL) && (w_state_nx == ST_NOMINAL);

  pid_gain_scaler u_scaler (
    .i_nom   (r_nom),
    .i_level (r_lvl),
    .o_gains (w_scaled)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_NOMINAL;
      r_lvl      <= '0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      r_nom      <= DEFAULTS;
      r_pend     <= DEFAULTS;
      r_pend_vld <= 1'b0;
      r_out      <= DEFAULTS;
      r_upd      <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_lvl   <= w_lvl_nx;
      r_cnt   <= w_cnt_nx;
      r_sat   <= w_sat_nx;

      // A load on the entry clk is newer than anything buffered
      if (cfg_load && r_state == ST_NOMINAL)
        r_nom <= w_cfg;
      else if (w_enter_nom)
        r_nom <= cfg_load ? w_cfg : (r_pend_vld ? r_pend : r_nom);

      if (w_enter_nom) begin
        r_pend_vld <= 1'b0;
      end else if (cfg_load && r_state != ST_NOMINAL) begin
        r_pend     <= w_cfg;
        r_pend_vld <= 1'b1;
      end

      r_out <= w_scaled;
      r_upd <= (w_scaled != r_out);
    end
  end

  // Next-state / counter / level decode
  always_comb begin
    w_state_nx = r_state;
    w_lvl_nx   = r_lvl;
    w_cnt_nx   = r_cnt;
    w_sat_nx   = r_sat;
    if (clk_100k_enable) begin
      case (r_state)
        ST_NOMINAL: begin
          if (overshoot_detected) begin
            w_state_nx = ST_DERATED;
            w_lvl_nx   = 2'd1;
            w_cnt_nx   = '0;
          end
        end
        ST_DERATED: begin
          if (r_cnt == DWELL_LAST) begin
            w_cnt_nx = '0;
            if (!overshoot_detected)     w_state_nx = ST_SETTLING;
            else if (r_lvl != MAX_LEVEL) w_lvl_nx   = r_lvl + 2'd1;
            else                         w_sat_nx   = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + 32'd1;
          end
        end
        ST_SETTLING: begin
          if (overshoot_detected) begin
            w_state_nx = ST_DERATED;
            w_cnt_nx   = '0;
          end else if (w_in_band) begin
            if (r_cnt == SETTLE_LAST) begin
              w_state_nx = ST_RECOVERING;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = r_cnt + 32'd1;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        ST_RECOVERING: begin
          if (overshoot_detected) begin
            w_state_nx = ST_DERATED;
            w_cnt_nx   = '0;
            if (r_lvl != MAX_LEVEL) w_lvl_nx = r_lvl + 2'd1;
          end else if (r_cnt == RECOVER_LAST) begin
            w_cnt_nx = '0;
            w_lvl_nx = r_lvl - 2'd1;
            if (r_lvl == 2'd1) w_state_nx = ST_NOMINAL;
          end else begin
            w_cnt_nx = r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
      if (w_lvl_nx != MAX_LEVEL) w_sat_nx = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    sched_state  = r_state;
    derate_level = r_lvl;
    saturated    = r_sat;
    kp_out       = r_out.kp;
    ki_out       = r_out.ki;
    kd_out       = r_out.kd;
    gain_update  = r_upd;
  end

endmodule

// File: tb/tb_pid_gain_scheduler.sv
// Directed + randomized bench for pid_gain_scheduler against an
// arithmetic reference model of the scheduling rules.
module tb_pid_gain_scheduler;

  localparam int DW = 50, ST = 200, RC = 100, BAND = 100;

  logic               clk = 1'b0;
  logic               reset, en, ovs, load;
  logic signed [31:0] err;
  logic [15:0]        kp_cfg, ki_cfg, kd_cfg;
  logic [15:0]        kp_out, ki_out, kd_out;
  logic               gain_update, saturated;
  logic [1:0]         derate_level, sched_state;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_state, m_lvl, m_cnt, m_sat, m_upd;
  int m_nom[3], m_pend[3], m_out[3];
  int m_pv;

  always #5 clk = ~clk;

  pid_gain_scheduler dut (
    .clk(clk), .reset(reset), .clk_100k_enable(en), .overshoot_detected(ovs),
    .error_pos(err), .cfg_load(load), .kp_cfg(kp_cfg), .ki_cfg(ki_cfg), .kd_cfg(kd_cfg),
    .kp_out(kp_out), .ki_out(ki_out), .kd_out(kd_out), .gain_update(gain_update),
    .derate_level(derate_level), .sched_state(sched_state), .saturated(saturated)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gain_of(input int idx, input int nom, input int lvl);
    int v;
    if (idx < 2) return nom / (1 << lvl);
    v = nom + (nom / 4) * lvl;
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_step();
    int ns, nl, nc, nsat, g;
    int cfg[3];
    longint a;
    bit inband, changed;
    cfg[0] = kp_cfg; cfg[1] = ki_cfg; cfg[2] = kd_cfg;
    if (reset) begin
      m_state = 0; m_lvl = 0; m_cnt = 0; m_sat = 0; m_upd = 0; m_pv = 0;
      m_nom[0] = 1024; m_nom[1] = 64; m_nom[2] = 256;
      m_out = m_nom;
      return;
    end
    changed = 0;
    for (int i = 0; i < 3; i++) begin
      g = gain_of(i, m_nom[i], m_lvl);
      if (g != m_out[i]) changed = 1;
      m_out[i] = g;
    end
    m_upd = changed;
    a = err;
    if (a < 0) a = -a;
    if (a > 64'd2147483647) a = 2147483647;
    inband = (a <= BAND);
    ns = m_state; nl = m_lvl; nc = m_cnt; nsat = m_sat;
    if (en) begin
      if (m_state == 0) begin
        if (ovs) begin ns = 1; nl = 1; nc = 0; end
      end else if (m_state == 1) begin
        if (m_cnt == DW - 1) begin
          nc = 0;
          if (!ovs) ns = 2;
          else if (m_lvl < 3) nl = m_lvl + 1;
          else nsat = 1;
        end else nc = m_cnt + 1;
      end else if (m_state == 2) begin
        if (ovs) begin ns = 1; nc = 0; end
        else if (!inband) nc = 0;
        else if (m_cnt == ST - 1) begin ns = 3; nc = 0; end
        else nc = m_cnt + 1;
      end else begin
        if (ovs) begin ns = 1; nc = 0; nl = (m_lvl < 3) ? m_lvl + 1 : 3; end
        else if (m_cnt == RC - 1) begin nc = 0; nl = m_lvl - 1; if (nl == 0) ns = 0; end
        else nc = m_cnt + 1;
      end
      if (nl < 3) nsat = 0;
    end
    if (load && m_state == 0) m_nom = cfg;
    else if (load) begin m_pend = cfg; m_pv = 1; end
    if (m_state != 0 && ns == 0) begin
      if (m_pv) m_nom = m_pend;
      m_pv = 0;
    end
    m_state = ns; m_lvl = nl; m_cnt = nc; m_sat = nsat;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("kp_out", 32'(kp_out), 32'(m_out[0]));
    chk("ki_out", 32'(ki_out), 32'(m_out[1]));
    chk("kd_out", 32'(kd_out), 32'(m_out[2]));
    chk("gain_update", 32'(gain_update), 32'(m_upd));
    chk("sched_state", 32'(sched_state), 32'(m_state));
    chk("derate_level", 32'(derate_level), 32'(m_lvl));
    chk("saturated", 32'(saturated), 32'(m_sat));
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  initial begin
    int sel;
    bit hit;
    reset = 1'b1; en = 1'b0; ovs = 1'b0; load = 1'b0; err = 32'sd0;
    kp_cfg = 16'd1024; ki_cfg = 16'd64; kd_cfg = 16'd256;
    cyc(); cyc();
    chk("rst_kp", 32'(kp_out), 32'd1024);
    chk("rst_kd", 32'(kd_out), 32'd256);
    chk("rst_state", 32'(sched_state), 32'd0);
    reset = 1'b0;

    // quiet operation
    en = 1'b1;
    repeat (1000) cyc();
    chk("quiet_kp", 32'(kp_out), 32'd1024);
    chk("quiet_ki", 32'(ki_out), 32'd64);
    chk("quiet_kd", 32'(kd_out), 32'd256);
    chk("quiet_state", 32'(sched_state), 32'd0);

    // sustained overshoot walks to level 3 and saturates
    ovs = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      cyc();
      if (t == 1)   chk("hold_lvl1", 32'(derate_level), 32'd1);
      if (t == 2)   chk("hold_kp512", 32'(kp_out), 32'd512);
      if (t == 2)   chk("hold_kd320", 32'(kd_out), 32'd320);
      if (t == 51)  chk("hold_lvl2", 32'(derate_level), 32'd2);
      if (t == 52)  chk("hold_kp256", 32'(kp_out), 32'd256);
      if (t == 52)  chk("hold_kd384", 32'(kd_out), 32'd384);
      if (t == 101) chk("hold_lvl3", 32'(derate_level), 32'd3);
      if (t == 102) chk("hold_kp128", 32'(kp_out), 32'd128);
      if (t == 102) chk("hold_kd448", 32'(kd_out), 32'd448);
      if (t == 150) chk("hold_sat0", 32'(saturated), 32'd0);
      if (t == 151) chk("hold_sat1", 32'(saturated), 32'd1);
    end
    ovs = 1'b0;
    do_reset();
    chk("midrst_kp", 32'(kp_out), 32'd1024);
    chk("midrst_lvl", 32'(derate_level), 32'd0);
    chk("midrst_sat", 32'(saturated), 32'd0);

    // single-level derate and full recovery
    err = 32'sd50;
    for (int t = 1; t <= 352; t++) begin
      ovs = (t == 1);
      cyc();
      if (t == 50)  chk("rec_still_der", 32'(sched_state), 32'd1);
      if (t == 51)  chk("rec_settling", 32'(sched_state), 32'd2);
      if (t == 250) chk("rec_still_set", 32'(sched_state), 32'd2);
      if (t == 251) chk("rec_recovering", 32'(sched_state), 32'd3);
      if (t == 351) chk("rec_nominal", 32'(sched_state), 32'd0);
      if (t == 352) chk("rec_kp1024", 32'(kp_out), 32'd1024);
    end

    // out-of-band sample restarts settling
    for (int t = 1; t <= 51; t++) begin ovs = (t == 1); cyc(); end
    ovs = 1'b0;
    for (int s = 1; s <= 350; s++) begin
      err = (s == 150) ? 32'sd101 : 32'sd50;
      cyc();
      if (s == 349) chk("band_restart_set", 32'(sched_state), 32'd2);
      if (s == 350) chk("band_restart_rec", 32'(sched_state), 32'd3);
    end
    // most-negative error is never in band
    ovs = 1'b1; cyc(); ovs = 1'b0;
    err = 32'sh8000_0000;
    repeat (50) cyc();
    chk("minint_set", 32'(sched_state), 32'd2);
    repeat (300) cyc();
    chk("minint_stuck", 32'(sched_state), 32'd2);
    chk("minint_lvl", 32'(derate_level), 32'd2);
    err = 32'sd50;
    do_reset();

    // load during derate is deferred until nominal
    ovs = 1'b1;
    repeat (51) cyc();
    load = 1'b1; kp_cfg = 16'd2000; cyc(); load = 1'b0;
    cyc();
    chk("defer_kp256", 32'(kp_out), 32'd256);
    ovs = 1'b0;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      cyc();
      if (sched_state == 2'd0) hit = 1;
    end
    chk("defer_reach_nominal", 32'(hit), 32'd1);
    chk("defer_entry_kp", 32'(kp_out), 32'd512);
    cyc();
    chk("defer_kp2000", 32'(kp_out), 32'd2000);
    chk("defer_pulse", 32'(gain_update), 32'd1);
    cyc();
    chk("defer_pulse_end", 32'(gain_update), 32'd0);
    do_reset();

    // load and overshoot on the same NOMINAL tick
    load = 1'b1; ovs = 1'b1; kp_cfg = 16'd3000; ki_cfg = 16'd64; kd_cfg = 16'd256;
    cyc();
    load = 1'b0;
    chk("simul_lvl1", 32'(derate_level), 32'd1);
    cyc();
    chk("simul_kp1500", 32'(kp_out), 32'd1500);
    ovs = 1'b0;
    do_reset();

    // kd clipping at full scale, then reset mid-derate
    load = 1'b1; kp_cfg = 16'd1024; kd_cfg = 16'hF000; ovs = 1'b0;
    cyc();
    load = 1'b0; ovs = 1'b1;
    repeat (102) cyc();
    chk("kdclip_lvl3", 32'(derate_level), 32'd3);
    chk("kdclip_ffff", 32'(kd_out), 32'hFFFF);
    do_reset();
    chk("kdclip_rst_kd", 32'(kd_out), 32'd256);
    chk("kdclip_rst_state", 32'(sched_state), 32'd0);
    ovs = 1'b0;

    // randomized traffic with sparse enables
    for (int i = 0; i < 6000; i++) begin
      en   = ($urandom_range(0, 1) == 1);
      ovs  = ($urandom_range(0, 49) == 0);
      sel  = $urandom_range(0, 99);
      if (sel < 90)      err = $signed(32'($urandom_range(0, 200))) - 32'sd100;
      else if (sel < 93) err = 32'sd101;
      else if (sel < 96) err = -32'sd101;
      else if (sel < 98) err = 32'sh8000_0000;
      else               err = $signed($urandom);
      load = ($urandom_range(0, 79) == 0);
      kp_cfg = 16'($urandom); ki_cfg = 16'($urandom); kd_cfg = 16'($urandom);
      reset = ($urandom_range(0, 1999) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
